// File: rtl/ebike_pkg.sv
// Shared constants and helpers for the e-bike pedal-sensor conditioning path.
package ebike_pkg;

    localparam int CAD_SAT   = 31;
    localparam int NP_THRESH = 2;
    localparam int TORQUE_W  = 12;
    localparam int AVG_SHIFT = 5;
    localparam int ACC_W     = 17;
    localparam int CAD_W     = 5;

    // Saturating increment used for both the running edge count and the latched cadence.
    function automatic logic [CAD_W-1:0] cad_add(input logic [CAD_W-1:0] cnt, input logic inc);
        if (inc && (cnt != CAD_W'(CAD_SAT)))
            return cnt + 1'b1;
        else
            return cnt;
    endfunction

endpackage

// File: rtl/sensor_cond_edge_sync.sv
// Cadence pulse synchroniser and rise detector; with CADENCE_FILT_EN defined a
// FILT_CYC-cycle stability filter sits between the synchroniser and the history flop.
module edge_sync
`ifdef CADENCE_FILT_EN
#(
    parameter int FILT_CYC = 16
)
`endif
(
    input  logic clk,
    input  logic rst,
    input  logic cadence_raw,
    output logic cad_rise
);

    logic sync1;
    logic sync2;
    logic hist;
    logic sig;

`ifdef CADENCE_FILT_EN
    localparam int CNT_W = $clog2(FILT_CYC + 1);

    logic             filt;
    logic [CNT_W-1:0] stable_cnt;

    // Filtered level follows the input only after FILT_CYC consecutive differing cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt       <= 1'b0;
            stable_cnt <= '0;
        end else if (sync2 != filt) begin
            if (stable_cnt == CNT_W'(FILT_CYC - 1)) begin
                filt       <= sync2;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end else begin
            stable_cnt <= '0;
        end
    end

    assign sig = filt;
`else
    assign sig = sync2;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            hist     <= 1'b0;
            cad_rise <= 1'b0;
        end else begin
            sync1    <= cadence_raw;
            sync2    <= sync1;
            hist     <= sig;
            cad_rise <= sig & ~hist;
        end
    end

endmodule

// File: rtl/sensor_cond.sv
// Pedal-sensor conditioning: windowed cadence count, not-pedaling flag and
// per-stroke exponential torque average. Optional glitch filter: CADENCE_FILT_EN.
module sensor_cond
    import ebike_pkg::*;
#(
    parameter int CAD_WIN_W = 24
`ifdef CADENCE_FILT_EN
    ,
    parameter int FILT_CYC  = 16
`endif
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic                cadence_raw,
    input  logic [TORQUE_W-1:0] torque_raw,
    output logic [TORQUE_W-1:0] avg_torque,
    output logic [CAD_W-1:0]    cadence,
    output logic                not_pedaling
);

    logic                 cad_rise;
    logic [CAD_WIN_W-1:0] win_cnt;
    logic                 terminal;
    logic [CAD_W-1:0]     edge_cnt;
    logic [CAD_W-1:0]     cadence_next;
    logic [ACC_W-1:0]     acc;

    edge_sync
`ifdef CADENCE_FILT_EN
        #(.FILT_CYC(FILT_CYC))
`endif
    u_edge_sync (
        .clk         (clk),
        .rst         (rst),
        .cadence_raw (cadence_raw),
        .cad_rise    (cad_rise)
    );

    assign terminal     = &win_cnt;
    // An edge landing in the terminal cycle is folded into the closing window.
    assign cadence_next = cad_add(edge_cnt, cad_rise);

    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt      <= '0;
            edge_cnt     <= '0;
            cadence      <= '0;
            not_pedaling <= 1'b1;
            acc          <= '0;
        end else begin
            win_cnt <= win_cnt + 1'b1;
            if (terminal) begin
                edge_cnt     <= '0;
                cadence      <= cadence_next;
                not_pedaling <= (cadence_next < CAD_W'(NP_THRESH));
            end else begin
                edge_cnt <= cadence_next;
            end
            // Steady state is T<<5, so the 17-bit accumulator cannot overflow.
            if (cad_rise)
                acc <= acc - (acc >> AVG_SHIFT) + ACC_W'(torque_raw);
        end
    end

    assign avg_torque = acc[ACC_W-1 -: TORQUE_W];

endmodule
